// File: rtl/mem_responder.sv
// mem_responder: fixed-latency word RAM serving the CPU memory handshake.
// Accepts one request while idle, commits it after LATENCY cycles, then pulses O_data_ready.
module mem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  I_execute,
  input  logic                  I_we,
  input  logic [ADDR_WIDTH-1:0] I_addr,
  input  logic [DATA_WIDTH-1:0] I_data,
  output logic                  O_mem_ready,
  output logic                  O_data_ready,
  output logic [DATA_WIDTH-1:0] O_data
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
  state_t state, state_next;
  logic [3:0] cnt;
  logic we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data;
  logic [DATA_WIDTH-1:0] ram [2**ADDR_WIDTH];
  logic accept, commit;
  always_comb begin
    accept = state == IDLE && I_execute;
    commit = state == WAIT && cnt == 4'd0;
    state_next = accept ? WAIT : commit ? RESP : state == WAIT ? WAIT : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      O_data <= '0;
    end else begin
      state <= state_next;
      if (accept) cnt <= CNT_INIT;
      else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (commit && !we) O_data <= ram[addr];
    end
  end
  // Request fields need no reset: they are only read after a fresh accept.
  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      we   <= I_we;
      addr <= I_addr;
      data <= I_data;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset && commit && we) ram[addr] <= data;
  end
  assign O_mem_ready  = state == IDLE;
  assign O_data_ready = state == RESP;
endmodule
